// File: rtl/sb_pkg.sv
// Shared types and constants for the sb bus RAM responder.
package sb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2,
      WR_RESP = 2'd3
   } sb_state_e;

   localparam logic        SB_BRESP_OKAY = 1'b0;
   localparam logic        SB_BRESP_ERR  = 1'b1;
   localparam logic [31:0] SB_ERR_RDATA  = 32'hDEAD_BEEF;

   // Bits [31:30] select the bus region and are never part of the RAM address.
   function automatic logic sbAddrErr(input logic [31:0] addr, input int aw);
      return ((addr[29:0] >> (aw + 2)) != 30'd0);
   endfunction

endpackage

// File: rtl/sb_ram_bank.sv
// Single-port 2**AW x 32 synchronous RAM with byte-lane write enables and a registered read port.
module sb_ram_bank #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] i_addr,
   input  logic          i_we,
   input  logic [3:0]    i_wstrb,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [2**AW];
   logic [31:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Output register only moves on a read strobe, so it holds data for the whole response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= 32'd0;
      end else if (i_re) begin
         r_q <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/sb_ram_slave.sv
// sb bus responder backed by an internal word RAM, one transaction at a time.
// Define SB_RAM_SLV_ERR_EN to flag out-of-range addresses instead of wrapping them.
module sb_ram_slave #(
   parameter int AW      = 10,
   parameter int RD_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sb_arvalid,
   output logic        sb_arready,
   input  logic [31:0] sb_araddr,
   output logic        sb_rvalid,
   input  logic        sb_rready,
   output logic [31:0] sb_rdata,
   input  logic        sb_wvalid,
   output logic        sb_wready,
   input  logic [31:0] sb_waddr,
   input  logic [31:0] sb_wdata,
   input  logic [3:0]  sb_wstrb,
   output logic        sb_bvalid,
   input  logic        sb_bready,
   output logic        sb_bresp
);

   import sb_pkg::*;

   sb_state_e     r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic          r_pendErr;
   logic          r_rdErr;
   logic          r_rvalid;
   logic          r_bvalid;
   logic          r_bresp;

   logic          w_wready;
   logic          w_arready;
   logic          w_wrAcc;
   logic          w_rdAcc;
   logic          w_rdGo;
   logic          w_wErr;
   logic          w_arErr;
   logic [AW-1:0] w_bankAddr;
   logic [31:0]   w_bankQ;
   logic          w_unused;

`ifdef SB_RAM_SLV_ERR_EN
   assign w_wErr  = sbAddrErr(sb_waddr, AW);
   assign w_arErr = sbAddrErr(sb_araddr, AW);
`else
   assign w_wErr  = 1'b0;
   assign w_arErr = 1'b0;
`endif

   // Writes win a same-cycle collision; the master keeps the read request up until IDLE returns.
   assign w_wready  = rst_n && (r_state == IDLE);
   assign w_arready = rst_n && (r_state == IDLE) && !sb_wvalid;
   assign w_wrAcc   = sb_wvalid && w_wready;
   assign w_rdAcc   = sb_arvalid && w_arready;
   assign w_rdGo    = (w_rdAcc && (RD_WAIT == 0)) ||
                      ((r_state == sb_pkg::RD_WAIT) && (r_cnt == 4'd0));

   assign w_bankAddr = w_wrAcc ? sb_waddr[AW+1:2] :
                       (w_rdAcc ? sb_araddr[AW+1:2] : r_idx);

   sb_ram_bank #(.AW(AW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_addr  (w_bankAddr),
      .i_we    (w_wrAcc && !w_wErr),
      .i_wstrb (sb_wstrb),
      .i_wdata (sb_wdata),
      .i_re    (w_rdGo),
      .o_rdata (w_bankQ)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_idx     <= '0;
         r_pendErr <= 1'b0;
         r_rdErr   <= 1'b0;
         r_rvalid  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= SB_BRESP_OKAY;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wrAcc) begin
                  r_state  <= WR_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wErr ? SB_BRESP_ERR : SB_BRESP_OKAY;
               end else if (w_rdAcc) begin
                  r_idx     <= sb_araddr[AW+1:2];
                  r_pendErr <= w_arErr;
                  if (RD_WAIT == 0) begin
                     r_state  <= RD_RESP;
                     r_rvalid <= 1'b1;
                     r_rdErr  <= w_arErr;
                  end else begin
                     r_state <= sb_pkg::RD_WAIT;
                     r_cnt   <= 4'(RD_WAIT - 1);
                  end
               end
            end
            sb_pkg::RD_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= RD_RESP;
                  r_rvalid <= 1'b1;
                  r_rdErr  <= r_pendErr;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RD_RESP: begin
               if (sb_rready) begin
                  r_state  <= IDLE;
                  r_rvalid <= 1'b0;
               end
            end
            WR_RESP: begin
               if (sb_bready) begin
                  r_state  <= IDLE;
                  r_bvalid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sb_arready = w_arready;
   assign sb_wready  = w_wready;
   assign sb_rvalid  = r_rvalid;
   assign sb_rdata   = r_rdErr ? SB_ERR_RDATA : w_bankQ;
   assign sb_bvalid  = r_bvalid;
   assign sb_bresp   = r_bresp;

   // Region and byte-offset address bits carry no information for the RAM itself.
   assign w_unused = &{1'b0, sb_araddr[31:AW+2], sb_araddr[1:0],
                       sb_waddr[31:AW+2], sb_waddr[1:0]};

endmodule

// File: tb/tb_sb_ram_slave.sv
// Scoreboard bench for sb_ram_slave: directed transactions push expected responses, a monitor checks them.
module tb_sb_ram_slave;

   localparam int AW      = 10;
   localparam int RD_WAIT = 1;
   localparam int BOUND   = 50;

   logic        clk;
   logic        rst_n;
   logic        sb_arvalid;
   logic        sb_arready;
   logic [31:0] sb_araddr;
   logic        sb_rvalid;
   logic        sb_rready;
   logic [31:0] sb_rdata;
   logic        sb_wvalid;
   logic        sb_wready;
   logic [31:0] sb_waddr;
   logic [31:0] sb_wdata;
   logic [3:0]  sb_wstrb;
   logic        sb_bvalid;
   logic        sb_bready;
   logic        sb_bresp;

   logic [31:0] expRdQ [$];
   logic        expBQ  [$];
   int          checkCount = 0;
   int          passCount  = 0;

   sb_ram_slave #(.AW(AW), .RD_WAIT(RD_WAIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sb_arvalid (sb_arvalid),
      .sb_arready (sb_arready),
      .sb_araddr  (sb_araddr),
      .sb_rvalid  (sb_rvalid),
      .sb_rready  (sb_rready),
      .sb_rdata   (sb_rdata),
      .sb_wvalid  (sb_wvalid),
      .sb_wready  (sb_wready),
      .sb_waddr   (sb_waddr),
      .sb_wdata   (sb_wdata),
      .sb_wstrb   (sb_wstrb),
      .sb_bvalid  (sb_bvalid),
      .sb_bready  (sb_bready),
      .sb_bresp   (sb_bresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Response monitor: every completed handshake must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sb_bvalid && sb_bready) begin
               if (expBQ.size() == 0) checkOutput("unexpected bvalid", {31'd0, sb_bvalid}, 32'd0);
               else checkOutput("bresp", {31'd0, sb_bresp}, {31'd0, expBQ.pop_front()});
            end
            if (sb_rvalid && sb_rready) begin
               if (expRdQ.size() == 0) checkOutput("unexpected rvalid", {31'd0, sb_rvalid}, 32'd0);
               else checkOutput("rdata", sb_rdata, expRdQ.pop_front());
            end
         end
      end
   end

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic expResp, input bit checkTiming);
      int n;
      @(posedge clk); #1;
      sb_wvalid = 1'b1;
      sb_waddr  = addr;
      sb_wdata  = data;
      sb_wstrb  = strb;
      n = 0;
      @(negedge clk);
      if (checkTiming) checkOutput("wready same cycle", {31'd0, sb_wready}, 32'd1);
      while (!sb_wready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (!sb_wready) checkOutput("wready timeout", {31'd0, sb_wready}, 32'd1);
      expBQ.push_back(expResp);
      @(posedge clk); #1;
      sb_wvalid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sb_bvalid && sb_bready) && n < BOUND);
      if (checkTiming) checkOutput("bvalid latency", 32'(n), 32'd1);
      if (!sb_bvalid) checkOutput("bvalid timeout", {31'd0, sb_bvalid}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic doRead(input logic [31:0] addr, input logic [31:0] exp, input bit checkLat, input int stall);
      int n;
      @(posedge clk); #1;
      sb_arvalid = 1'b1;
      sb_araddr  = addr;
      if (stall > 0) sb_rready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!sb_arready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (!sb_arready) checkOutput("arready timeout", {31'd0, sb_arready}, 32'd1);
      expRdQ.push_back(exp);
      @(posedge clk); #1;
      sb_arvalid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sb_rvalid && n < BOUND);
      if (!sb_rvalid) checkOutput("rvalid timeout", {31'd0, sb_rvalid}, 32'd1);
      if (checkLat) checkOutput("read latency", 32'(n), 32'(1 + RD_WAIT));
      if (stall > 0) begin
         for (int i = 0; i < stall; i++) begin
            checkOutput("stall rvalid", {31'd0, sb_rvalid}, 32'd1);
            checkOutput("stall rdata", sb_rdata, exp);
            checkOutput("stall arready", {31'd0, sb_arready}, 32'd0);
            checkOutput("stall wready", {31'd0, sb_wready}, 32'd0);
            @(negedge clk);
         end
         @(posedge clk); #1;
         sb_rready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus();
      int n;
      sb_arvalid = 1'b0;
      sb_araddr  = 32'd0;
      sb_wvalid  = 1'b0;
      sb_waddr   = 32'd0;
      sb_wdata   = 32'd0;
      sb_wstrb   = 4'd0;
      sb_rready  = 1'b1;
      sb_bready  = 1'b1;
      rst_n      = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset arready", {31'd0, sb_arready}, 32'd0);
      checkOutput("reset wready", {31'd0, sb_wready}, 32'd0);
      checkOutput("reset rvalid", {31'd0, sb_rvalid}, 32'd0);
      checkOutput("reset bvalid", {31'd0, sb_bvalid}, 32'd0);
      checkOutput("reset rdata", sb_rdata, 32'd0);
      checkOutput("reset bresp", {31'd0, sb_bresp}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle wready", {31'd0, sb_wready}, 32'd1);
      checkOutput("idle arready", {31'd0, sb_arready}, 32'd1);

      doWrite(32'h4000_0010, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
      doRead (32'h4000_0010, 32'h1234_5678, 1'b1, 0);
      doWrite(32'h4000_0010, 32'hFFFF_AAFF, 4'b0010, 1'b0, 1'b0);
      doRead (32'h4000_0010, 32'h1234_AA78, 1'b1, 0);
      doWrite(32'h4000_0013, 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
      doRead (32'h4000_0012, 32'h1234_AA78, 1'b0, 0);

      // Collision: write and read raised together in IDLE.
      @(posedge clk); #1;
      sb_wvalid  = 1'b1;
      sb_waddr   = 32'h4000_0020;
      sb_wdata   = 32'hA5A5_0001;
      sb_wstrb   = 4'hF;
      sb_arvalid = 1'b1;
      sb_araddr  = 32'h4000_0020;
      @(negedge clk);
      checkOutput("collide wready", {31'd0, sb_wready}, 32'd1);
      checkOutput("collide arready", {31'd0, sb_arready}, 32'd0);
      expBQ.push_back(1'b0);
      @(posedge clk); #1;
      sb_wvalid = 1'b0;
      @(negedge clk);
      checkOutput("collide bvalid", {31'd0, sb_bvalid}, 32'd1);
      checkOutput("collide arready in WR_RESP", {31'd0, sb_arready}, 32'd0);
      expRdQ.push_back(32'hA5A5_0001);
      @(negedge clk);
      checkOutput("collide arready after bresp", {31'd0, sb_arready}, 32'd1);
      @(posedge clk); #1;
      sb_arvalid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sb_rvalid && n < BOUND);
      checkOutput("collide read latency", 32'(n), 32'(1 + RD_WAIT));
      @(posedge clk); #1;

      doRead(32'h4000_0020, 32'hA5A5_0001, 1'b1, 5);

      doWrite(32'h4000_0000, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0);
`ifdef SB_RAM_SLV_ERR_EN
      doWrite(32'h4000_2000, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
      doRead (32'h4000_2000, 32'hDEAD_BEEF, 1'b1, 0);
      doRead (32'h4000_0000, 32'h0BAD_C0DE, 1'b0, 0);
`else
      doWrite(32'h4000_2000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
      doRead (32'h4000_0000, 32'hCAFE_F00D, 1'b0, 0);
      doRead (32'h4000_2000, 32'hCAFE_F00D, 1'b1, 0);
`endif

      // Reset lands while the read is still waiting; no response may follow.
      @(posedge clk); #1;
      sb_arvalid = 1'b1;
      sb_araddr  = 32'h4000_0010;
      @(negedge clk);
      checkOutput("pre-reset arready", {31'd0, sb_arready}, 32'd1);
      @(posedge clk); #1;
      sb_arvalid = 1'b0;
      #1;
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("mid-reset rvalid", {31'd0, sb_rvalid}, 32'd0);
         checkOutput("mid-reset arready", {31'd0, sb_arready}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post-reset rvalid", {31'd0, sb_rvalid}, 32'd0);
      end
      doWrite(32'h4000_0030, 32'h600D_F00D, 4'hF, 1'b0, 1'b1);
      doRead (32'h4000_0030, 32'h600D_F00D, 1'b1, 0);
      doRead (32'h4000_0010, 32'h1234_AA78, 1'b0, 0);

      repeat (3) @(negedge clk);
      checkOutput("read queue drained", 32'(expRdQ.size()), 32'd0);
      checkOutput("bresp queue drained", 32'(expBQ.size()), 32'd0);
   endtask

   initial begin
      applyStimulus();
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
